// File: rtl/imem_loader.sv
// Boot loader: turns a length-prefixed big-endian byte stream into sequential instruction memory writes.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int          MAX_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [10:0] words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR} state_t;
`endif

   localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

   state_t      r_state;
   logic        r_in_ready, r_mem_we, r_cpu_hold, r_busy, r_done, r_error;
   logic [31:0] r_mem_addr, r_mem_wdata, r_asm;
   logic [10:0] r_words_loaded, r_count;
   logic [7:0]  r_len_hi;
   logic [1:0]  r_idx;
   logic        r_fin;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  r_csum;
`endif

   logic        w_accept;
   logic [15:0] w_len;
   logic [31:0] w_word;
   logic        w_last;

   assign w_accept = in_valid && r_in_ready;
   assign w_len    = {r_len_hi, in_data};
   assign w_word   = {r_asm[23:0], in_data};
   assign w_last   = (r_words_loaded + 11'd1) == r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_in_ready     <= 1'b0;
         r_mem_we       <= 1'b0;
         r_mem_addr     <= BASE_ADDR;
         r_mem_wdata    <= 32'd0;
         r_cpu_hold     <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_error        <= 1'b0;
         r_words_loaded <= 11'd0;
         r_count        <= 11'd0;
         r_len_hi       <= 8'd0;
         r_asm          <= 32'd0;
         r_idx          <= 2'd0;
         r_fin          <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_csum         <= 8'd0;
`endif
      end else begin
         r_mem_we <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (w_accept) r_csum <= r_csum ^ in_data;
`endif
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  r_state        <= S_LEN_HI;
                  r_done         <= 1'b0;
                  r_error        <= 1'b0;
                  r_words_loaded <= 11'd0;
                  r_idx          <= 2'd0;
                  r_busy         <= 1'b1;
                  r_cpu_hold     <= 1'b1;
                  r_in_ready     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_csum         <= 8'd0;
`endif
               end
            end
            S_LEN_HI: begin
               if (w_accept) begin
                  r_len_hi <= in_data;
                  r_state  <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (w_accept) begin
                  if ({1'b0, w_len} > MAX_N) begin
                     r_state    <= S_ERR;
                     r_error    <= 1'b1;
                     r_busy     <= 1'b0;
                     r_in_ready <= 1'b0;
                  end else if (w_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     r_state    <= S_CSUM;
`else
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_busy     <= 1'b0;
                     r_cpu_hold <= 1'b0;
                     r_in_ready <= 1'b0;
`endif
                  end else begin
                     r_count <= w_len[10:0];
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               // r_fin marks the write cycle of the final word; leave DATA once it has passed
               if (r_fin) begin
                  r_fin <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_state    <= S_CSUM;
                  r_in_ready <= 1'b1;
`else
                  r_state    <= S_DONE;
                  r_done     <= 1'b1;
                  r_busy     <= 1'b0;
                  r_cpu_hold <= 1'b0;
`endif
               end else if (w_accept) begin
                  r_asm <= w_word;
                  r_idx <= r_idx + 2'd1;
                  if (r_idx == 2'd3) begin
                     r_mem_we       <= 1'b1;
                     r_mem_wdata    <= w_word;
                     r_mem_addr     <= BASE_ADDR + {19'd0, r_words_loaded, 2'b00};
                     r_words_loaded <= r_words_loaded + 11'd1;
                     if (w_last) begin
                        r_fin      <= 1'b1;
                        r_in_ready <= 1'b0;
                     end
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (w_accept) begin
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b0;
                  if (in_data == r_csum) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_cpu_hold <= 1'b0;
                  end else begin
                     r_state <= S_ERR;
                     r_error <= 1'b1;
                  end
               end
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready     = r_in_ready;
   assign mem_we       = r_mem_we;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign cpu_hold     = r_cpu_hold;
   assign busy         = r_busy;
   assign done         = r_done;
   assign error        = r_error;
   assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected writes queued at issue time, popped by a monitor.
module tb_imem_loader;
   localparam int          MAXW = 1024;
   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_ready, mem_we, cpu_hold, busy, done, error;
   logic [31:0] mem_addr, mem_wdata;
   logic [10:0] words_loaded;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   logic [31:0] words[$];

   imem_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write pulse must match the oldest outstanding expected write
   always @(negedge clk) begin
      if (!reset && mem_we) begin
         if (exp_addr.size() == 0) begin
            check("unexpected_write", 32'd1, 32'd0);
         end else begin
            check("write_addr", mem_addr, exp_addr.pop_front());
            check("write_data", mem_wdata, exp_data.pop_front());
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      check({tag, "_mem_addr"}, mem_addr, BASE);
      check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_error"}, {31'd0, error}, 32'd0);
      check({tag, "_words_loaded"}, {21'd0, words_loaded}, 32'd0);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   // One load session: model builds the byte stream and expected outcome from the stream rules
   task automatic run_session(input int n, input int gap_max, input bit bad_csum, input bit poke_start);
      logic [7:0]  stream[$];
      logic [7:0]  x;
      logic [31:0] w;
      logic [15:0] n16;
      bit          exp_ok;
      int          cnt;
      n16 = 16'(n);
      stream.push_back(n16[15:8]);
      stream.push_back(n16[7:0]);
      exp_ok = (n <= MAXW);
      if (exp_ok) begin
         for (int i = 0; i < n; i++) begin
            w = (i < words.size()) ? words[i] : $urandom;
            for (int k = 3; k >= 0; k--) stream.push_back(w[k*8 +: 8]);
            exp_addr.push_back(BASE + 32'(4 * i));
            exp_data.push_back(w);
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         x = 8'd0;
         foreach (stream[i]) x = x ^ stream[i];
         stream.push_back(bad_csum ? (x ^ 8'h01) : x);
         if (bad_csum) exp_ok = 1'b0;
`endif
      end
      words.delete();

      pulse_start();
      foreach (stream[i]) begin
         send_byte(stream[i]);
         if (i != stream.size() - 1) begin
            repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            if (poke_start && ($urandom_range(3, 0) == 0)) pulse_start();
         end
      end

      cnt = 0;
      while (busy && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      check("idle_timeout", {31'd0, busy}, 32'd0);
      check("done", {31'd0, done}, {31'd0, exp_ok});
      check("error", {31'd0, error}, {31'd0, !exp_ok});
      check("cpu_hold", {31'd0, cpu_hold}, {31'd0, !exp_ok});
      check("words_loaded", {21'd0, words_loaded}, (n <= MAXW) ? 32'(n) : 32'd0);
      check("writes_outstanding", 32'(exp_addr.size()), 32'd0);
      $display("session N=%0d gaps<=%0d bad_csum=%0d -> done=%0d error=%0d words_loaded=%0d",
               n, gap_max, bad_csum, done, error, words_loaded);
      exp_addr.delete();
      exp_data.delete();
      @(negedge clk);
   endtask

   initial begin
      #1;
      check_reset_outputs("reset");
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("idle");

      words = '{32'h2024000A, 32'h00221820};
      run_session(2, 0, 1'b0, 1'b0);
      run_session(0, 0, 1'b0, 1'b0);
      run_session(1025, 0, 1'b0, 1'b0);
      run_session(1, 0, 1'b0, 1'b0);
      run_session(1, 2, 1'b0, 1'b0);

      // Abort mid-word: no write, outputs back to reset values at once
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'hAB);
      send_byte(8'hCD);
      #2 reset = 1'b1;
      #1 check_reset_outputs("midload_reset");
      $display("reset asserted after 2 data bytes of word 0");
      exp_addr.delete();
      exp_data.delete();
      @(negedge clk) reset = 1'b0;
      run_session(1, 1, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      words = '{32'h12345678};
      run_session(1, 0, 1'b0, 1'b0);
      words = '{32'h12345678};
      run_session(1, 0, 1'b1, 1'b0);
`endif

      for (int s = 0; s < 30; s++) begin
         int n;
         n = ($urandom_range(7, 0) == 0) ? int'($urandom_range(65535, 1025)) : int'($urandom_range(6, 0));
         run_session(n, 3, 1'($urandom_range(3, 0) == 0), 1'($urandom_range(1, 0)));
      end

      run_session(MAXW, 0, 1'b0, 1'b0);
      run_session(MAXW + 1, 0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
